// File: rtl/asp_dfh_csr_pkg.sv
// Shared definitions for the DFH CSR responder: register map and DFH layout.
package asp_dfh_csr_pkg;

    // Register word offsets within the low 8-word window.
    localparam logic [2:0] DFH_ADDR      = 3'd0;
    localparam logic [2:0] GUID_L_ADDR   = 3'd1;
    localparam logic [2:0] GUID_H_ADDR   = 3'd2;
    localparam logic [2:0] SCRATCH_ADDR  = 3'd3;
    localparam logic [2:0] RD_COUNT_ADDR = 3'd4;
    localparam logic [2:0] WR_COUNT_ADDR = 3'd5;
    localparam logic [2:0] CTRL_ADDR     = 3'd6;
    // Selector used for any address outside the register window.
    localparam logic [2:0] UNMAPPED_SEL  = 3'd7;

    typedef struct packed {
        logic [3:0]  feature_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next_dfh_offset;
        logic [3:0]  feature_rev;
        logic [11:0] feature_id;
    } t_dfh;

    function automatic t_dfh build_dfh(
        input logic [3:0]  ftype,
        input logic [3:0]  frev,
        input logic [11:0] fid,
        input logic [23:0] next_off,
        input logic        eol
    );
        t_dfh d;
        d.feature_type    = ftype;
        d.rsvd            = '0;
        d.eol             = eol;
        d.next_dfh_offset = next_off;
        d.feature_rev     = frev;
        d.feature_id      = fid;
        return d;
    endfunction

endpackage

// File: rtl/asp_mmio_dfh_csr_rsp.sv
// Avalon-MM MMIO responder: DFH, GUID, scratch and activity counters with a
// fixed two-cycle read latency. Terminates host MMIO on links without kernel CSRs.
module asp_mmio_dfh_csr_rsp
    import asp_dfh_csr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter logic [3:0]  FEATURE_TYPE    = 4'h1,
    parameter logic [3:0]  FEATURE_REV     = 4'h0,
    parameter logic [11:0] FEATURE_ID      = 12'h0,
    parameter logic [23:0] NEXT_DFH_OFFSET = 24'h0,
    parameter logic        END_OF_LIST     = 1'b1,
    parameter logic [63:0] GUID_L          = 64'h0,
    parameter logic [63:0] GUID_H          = 64'h0
) (
    input  logic                  pClk,
    input  logic                  pClk_reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [63:0]           writedata,
    input  logic [7:0]            byteenable,
    output logic                  waitrequest,
    output logic [63:0]           readdata,
    output logic                  readdatavalid
);

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "asp_mmio_dfh_csr_rsp: DATA_WIDTH must be 64");
    end
    if (ADDR_WIDTH < 4) begin : g_bad_addr_width
        $fatal(1, "asp_mmio_dfh_csr_rsp: ADDR_WIDTH must be at least 4");
    end

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam t_dfh DfhValue = build_dfh(FEATURE_TYPE, FEATURE_REV, FEATURE_ID,
                                          NEXT_DFH_OFFSET, END_OF_LIST);

    state_e      state_q, state_d;
    logic [63:0] scratch_q, scratch_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_sel_q, s1_sel_d;
    logic [63:0] readdata_q, readdata_d;
    logic        readdatavalid_q, readdatavalid_d;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_acc;
    logic        rd_acc;
    logic        ctrl_clear;
    logic [63:0] rd_mux;

    assign waitrequest   = (state_q == StInit);
    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

    // FSM next state: leave INIT on the first cycle out of reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Acceptance and address decode; a simultaneous read+write is handled as a write.
    always_comb begin
        hit        = (address[ADDR_WIDTH-1:3] == '0);
        sel        = hit ? address[2:0] : UNMAPPED_SEL;
        wr_acc     = write & ~waitrequest;
        rd_acc     = read & ~write & ~waitrequest;
        ctrl_clear = wr_acc & (sel == CTRL_ADDR) & writedata[0];
    end

    // Scratch, counters and stage-1 capture.
    always_comb begin
        scratch_d = scratch_q;
        if (wr_acc && (sel == SCRATCH_ADDR)) begin
            for (int i = 0; i < 8; i++) begin
                if (byteenable[i]) begin
                    scratch_d[8*i +: 8] = writedata[8*i +: 8];
                end
            end
        end
        rd_cnt_d = rd_cnt_q + 32'(rd_acc);
        wr_cnt_d = wr_cnt_q + 32'(wr_acc);
        // The clear overrides the increment of the CTRL write itself.
        if (ctrl_clear) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
        s1_valid_d = rd_acc;
        s1_sel_d   = rd_acc ? sel : s1_sel_q;
    end

    // Stage 2: sample register contents the cycle after acceptance.
    always_comb begin
        rd_mux = '0;
        case (s1_sel_q)
            DFH_ADDR:      rd_mux = DfhValue;
            GUID_L_ADDR:   rd_mux = GUID_L;
            GUID_H_ADDR:   rd_mux = GUID_H;
            SCRATCH_ADDR:  rd_mux = scratch_q;
            RD_COUNT_ADDR: rd_mux = {32'h0, rd_cnt_q};
            WR_COUNT_ADDR: rd_mux = {32'h0, wr_cnt_q};
            default:       rd_mux = '0;
        endcase
        readdatavalid_d = s1_valid_q;
        readdata_d      = s1_valid_q ? rd_mux : readdata_q;
    end

    // State registers with synchronous reset; in-flight reads are discarded.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            state_q         <= StInit;
            scratch_q       <= '0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
            s1_valid_q      <= 1'b0;
            s1_sel_q        <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            scratch_q       <= scratch_d;
            rd_cnt_q        <= rd_cnt_d;
            wr_cnt_q        <= wr_cnt_d;
            s1_valid_q      <= s1_valid_d;
            s1_sel_q        <= s1_sel_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    // Host must never present read and write in the same cycle.
    a_no_rd_wr: assert property (@(posedge pClk) disable iff (pClk_reset) !(read && write))
        else $error("asp_mmio_dfh_csr_rsp: read and write asserted together");

endmodule

// File: tb/tb_asp_mmio_dfh_csr_rsp.sv
// Directed self-checking bench for asp_mmio_dfh_csr_rsp.
module tb_asp_mmio_dfh_csr_rsp;

    // {type=1, rsvd=0, eol=0, next=0x001000, rev=0, id=0x0A5}:
    // 0x1<<60 | 0x1000<<16 | 0xA5
    localparam logic [63:0] DfhExp = 64'h1000_0000_1000_00A5;
    localparam logic [63:0] GuidL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] GuidH  = 64'hDEAD_BEEF_0000_0001;

    logic        pClk          = 1'b0;
    logic        pClk_reset    = 1'b1;
    logic [15:0] address       = '0;
    logic        read          = 1'b0;
    logic        write         = 1'b0;
    logic [63:0] writedata     = '0;
    logic [7:0]  byteenable    = '0;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;

    int checks = 0;
    int errors = 0;

    always #5 pClk = ~pClk;

    asp_mmio_dfh_csr_rsp #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (64),
        .FEATURE_TYPE   (4'h1),
        .FEATURE_REV    (4'h0),
        .FEATURE_ID     (12'h0A5),
        .NEXT_DFH_OFFSET(24'h1000),
        .END_OF_LIST    (1'b0),
        .GUID_L         (GuidL),
        .GUID_H         (GuidH)
    ) dut (
        .pClk         (pClk),
        .pClk_reset   (pClk_reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        tick();
        write      = 1'b0;
    endtask

    // Read accepted in cycle N: response in N+2, then held with valid low.
    task automatic do_read(input logic [15:0] a, input logic [63:0] exp, input string tag);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        check({tag, " rdv_n1"}, 64'(readdatavalid), 64'd0);
        tick();
        check({tag, " rdv_n2"}, 64'(readdatavalid), 64'd1);
        check({tag, " data"}, readdata, exp);
        tick();
        check({tag, " rdv_n3"}, 64'(readdatavalid), 64'd0);
        check({tag, " hold"}, readdata, exp);
    endtask

    initial begin
        // Reset release
        pClk_reset = 1'b1;
        repeat (5) tick();
        check("rst waitreq", 64'(waitrequest), 64'd1);
        check("rst rdv", 64'(readdatavalid), 64'd0);
        check("rst rdata", readdata, 64'd0);
        pClk_reset = 1'b0;
        check("rel0 waitreq", 64'(waitrequest), 64'd1);
        check("rel0 rdv", 64'(readdatavalid), 64'd0);
        tick();
        check("rel1 waitreq", 64'(waitrequest), 64'd0);
        check("rel1 rdv", 64'(readdatavalid), 64'd0);
        tick();
        check("rel2 rdv", 64'(readdatavalid), 64'd0);

        // Back-to-back reads of words 0, 2, 7
        address = 16'd0; read = 1'b1;
        tick();
        address = 16'd2;
        check("b2b n1 rdv", 64'(readdatavalid), 64'd0);
        tick();
        address = 16'd7;
        check("b2b dfh rdv", 64'(readdatavalid), 64'd1);
        check("b2b dfh", readdata, DfhExp);
        tick();
        read = 1'b0;
        check("b2b guidh rdv", 64'(readdatavalid), 64'd1);
        check("b2b guidh", readdata, GuidH);
        tick();
        check("b2b w7 rdv", 64'(readdatavalid), 64'd1);
        check("b2b w7", readdata, 64'd0);
        tick();
        check("b2b end rdv", 64'(readdatavalid), 64'd0);

        do_read(16'd1, GuidL, "guidl");
        do_read(16'd6, 64'd0, "ctrl rd");
        do_read(16'h0008, 64'd0, "upper unmapped");
        do_write(16'd0, '1, 8'hFF);
        do_read(16'd0, DfhExp, "dfh ro");

        // Scratch byte enables and aliasing
        do_write(16'd3, 64'h1122_3344_5566_7788, 8'hFF);
        do_write(16'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        do_read(16'd3, 64'h1122_3344_AAAA_AAAA, "scratch be");
        do_write(16'h000B, 64'd0, 8'hFF);
        do_read(16'd3, 64'h1122_3344_AAAA_AAAA, "scratch alias");

        // Write at N, read at N+1
        do_write(16'd3, 64'd5, 8'hFF);
        do_read(16'd3, 64'd5, "hazard");

        // Counters
        do_write(16'd6, 64'd1, 8'hFF);
        do_write(16'd3, 64'h10, 8'hFF);
        do_write(16'd3, 64'h20, 8'hFF);
        do_write(16'd3, 64'h30, 8'hFF);
        do_read(16'd3, 64'h30, "cnt rd1");
        do_read(16'd3, 64'h30, "cnt rd2");
        do_read(16'd4, 64'd3, "rd_count");
        do_read(16'd5, 64'd3, "wr_count");
        do_write(16'd6, 64'd1, 8'hFF);
        do_read(16'd5, 64'd0, "wr_count clr");
        do_write(16'd6, 64'd2, 8'hFF);
        do_read(16'd5, 64'd1, "ctrl bit1 noclr");
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt_q;
        do_read(16'd4, 64'd0, "rd_count wrap");
        do_read(16'd4, 64'd1, "rd_count post wrap");

        // Reset with a read in flight
        address = 16'd3; read = 1'b1;
        tick();
        read = 1'b0;
        pClk_reset = 1'b1;
        check("mid n1 rdv", 64'(readdatavalid), 64'd0);
        tick();
        check("mid n2 rdv", 64'(readdatavalid), 64'd0);
        check("mid waitreq", 64'(waitrequest), 64'd1);
        check("mid rdata", readdata, 64'd0);
        tick();
        pClk_reset = 1'b0;
        check("mid rel rdv", 64'(readdatavalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid idle rdv", 64'(readdatavalid), 64'd0);
        end
        do_read(16'd3, 64'd0, "scratch after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
